// File: rtl/chad_pkg.sv
// rtl/chad_pkg.sv - shared constants and loader state encoding for the chad boot path
//
// SPI_READ_CMD : flash READ opcode sent ahead of the 24-bit image address
// BLANK_LEN    : header value of an erased flash, treated as "no image"
// loader_state_t : boot loader sequencing states
package chad_pkg;

    localparam logic [7:0]  SPI_READ_CMD = 8'h03;
    localparam logic [15:0] BLANK_LEN    = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        DATA,
        FIN,
        DONE
    } loader_state_t;

endpackage

// File: rtl/code_loader_spi.sv
// rtl/code_loader_spi.sv - SPI mode-0 bit engine (divider, SCK, shift registers, bit counter)
//
// clk, resetq : clock, asynchronous active-low reset
// start_i     : level request; a transfer begins when idle, and at the end of a
//               transfer a still-high start_i chains the next one with no gap
// nbits_i     : bits in the next transfer, tx_i : MSB-first data for it
// busy_o      : transfer in progress (SCK may be toggling)
// last_o      : one-cycle pulse on the rising SCK edge of the final bit
// rdata_o     : last 16 sampled bits, including the bit sampled this cycle
// sck_o, mosi_o, miso_i : SPI pins
module code_loader_spi
    import chad_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        start_i,
    input  logic [5:0]  nbits_i,
    input  logic [31:0] tx_i,
    output logic        busy_o,
    output logic        last_o,
    output logic [15:0] rdata_o,
    output logic        sck_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    localparam int             DW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLKDIV - 1);

    logic          busy_q;
    logic          sck_q;
    logic [DW-1:0] div_q;
    logic [5:0]    bitcnt_q;
    logic [31:0]   shreg_q;
    logic [14:0]   rx_q;
    logic          phase_end;

    assign phase_end = busy_q && (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            busy_q   <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            rx_q     <= '0;
        end else if (!busy_q) begin
            if (start_i) begin
                busy_q   <= 1'b1;
                sck_q    <= 1'b0;
                div_q    <= '0;
                bitcnt_q <= nbits_i;
                shreg_q  <= tx_i;
            end
        end else if (phase_end) begin
            div_q <= '0;
            if (!sck_q) begin
                sck_q <= 1'b1;
                rx_q  <= {rx_q[13:0], miso_i};
            end else begin
                // Falling edge: MOSI only moves here, while SCK is low.
                sck_q <= 1'b0;
                if (bitcnt_q == 6'd1) begin
                    if (start_i) begin
                        bitcnt_q <= nbits_i;
                        shreg_q  <= tx_i;
                    end else begin
                        busy_q  <= 1'b0;
                        shreg_q <= '0;
                    end
                end else begin
                    bitcnt_q <= bitcnt_q - 6'd1;
                    shreg_q  <= {shreg_q[30:0], 1'b0};
                end
            end
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    assign busy_o  = busy_q;
    assign last_o  = phase_end && !sck_q && (bitcnt_q == 6'd1);
    assign rdata_o = {rx_q, miso_i};
    assign sck_o   = sck_q;
    assign mosi_o  = shreg_q[31];

endmodule

// File: rtl/code_loader.sv
// rtl/code_loader.sv - boot loader: copies a flash image into code RAM, then releases the chad core
//
// clk, resetq        : clock, asynchronous active-low reset
// cpu_resetq         : core reset, held low until the image is loaded
// boot_done/boot_err : load finished (sticky) / header was blank
// code_addr, insn    : core fetch port, one-cycle registered read
// spi_cs_n/sck/mosi/miso : flash pins, SPI mode 0
module code_loader
    import chad_pkg::*;
#(
    parameter int          ABITS  = 13,
    parameter int          CLKDIV = 2,
    parameter logic [23:0] BASE   = 24'h000000
) (
    input  logic        clk,
    input  logic        resetq,
    output logic        cpu_resetq,
    output logic        boot_done,
    output logic        boot_err,
    input  logic [14:0] code_addr,
    output logic [15:0] insn,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int          LW    = ABITS + 1;
    localparam logic [16:0] DEPTH = 17'(1) << ABITS;

    loader_state_t state_q;
    logic          cs_n_q;
    logic          done_q;
    logic          err_q;
    logic          cpu_resetq_q;
    logic [LW-1:0] waddr_q;
    logic [LW-1:0] len_q;
    logic [15:0]   insn_q;
    logic [15:0]   ram_q [0:(1<<ABITS)-1];

    logic          spi_start;
    logic          spi_cmd_phase;
    logic [5:0]    spi_nbits;
    logic [31:0]   spi_tx;
    logic          spi_busy;
    logic          spi_last;
    logic [15:0]   spi_rdata;
    logic          ram_we;

    // The engine is kicked from IDLE so the command starts on the same edge
    // cs_n falls; state changes happen on the last sample edge, ahead of the
    // falling edge where the engine decides whether to chain another word.
    assign spi_start     = (state_q == IDLE) || (state_q == CMD) ||
                           (state_q == LEN)  || (state_q == DATA);
    assign spi_cmd_phase = (state_q == IDLE) || (state_q == CMD);
    assign spi_nbits     = spi_cmd_phase ? 6'd32 : 6'd16;
    assign spi_tx        = spi_cmd_phase ? {SPI_READ_CMD, BASE} : 32'd0;
    assign ram_we        = (state_q == DATA) && spi_last;

    code_loader_spi #(.CLKDIV(CLKDIV)) u_spi (
        .clk     (clk),
        .resetq  (resetq),
        .start_i (spi_start),
        .nbits_i (spi_nbits),
        .tx_i    (spi_tx),
        .busy_o  (spi_busy),
        .last_o  (spi_last),
        .rdata_o (spi_rdata),
        .sck_o   (spi_sck),
        .mosi_o  (spi_mosi),
        .miso_i  (spi_miso)
    );

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q      <= IDLE;
            cs_n_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_resetq_q <= 1'b0;
            waddr_q      <= '0;
            len_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cs_n_q  <= 1'b0;
                    state_q <= CMD;
                end
                CMD: begin
                    if (spi_last) state_q <= LEN;
                end
                LEN: begin
                    if (spi_last) begin
                        if (spi_rdata == BLANK_LEN) begin
                            err_q   <= 1'b1;
                            state_q <= FIN;
                        end else if (spi_rdata == 16'd0) begin
                            state_q <= FIN;
                        end else begin
                            len_q   <= ({1'b0, spi_rdata} > DEPTH) ? LW'(DEPTH) : LW'(spi_rdata);
                            waddr_q <= '0;
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (spi_last) begin
                        waddr_q <= waddr_q + LW'(1);
                        if (waddr_q + LW'(1) == len_q) state_q <= FIN;
                    end
                end
                FIN: begin
                    // Wait for the final falling edge so SCK is low before cs_n rises.
                    if (!spi_busy) begin
                        cs_n_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q       <= 1'b1;
                    cpu_resetq_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[waddr_q[ABITS-1:0]] <= spi_rdata;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) insn_q <= '0;
        else         insn_q <= ram_q[code_addr[ABITS-1:0]];
    end

    if (ABITS < 15) begin : g_addr_tie
        logic unused_addr_bits;
        assign unused_addr_bits = ^code_addr[14:ABITS];
    end

    assign cpu_resetq = cpu_resetq_q;
    assign boot_done  = done_q;
    assign boot_err   = err_q;
    assign insn       = insn_q;
    assign spi_cs_n   = cs_n_q;

endmodule

// File: tb/tb_code_loader.sv
// tb/tb_code_loader.sv - self-checking bench for code_loader with a behavioural SPI flash
module tb_code_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rstq = 3'b000;
    logic [2:0]  cpu_rq, bdone, berr, cs_n, sck, mosi, miso;
    logic [15:0] insn  [3];
    logic [14:0] caddr [3];
    logic [15:0] img   [3][128];
    int          fcnt_w [3];
    int          sbits_w[3];
    int          pmin_w [3];
    int          pmax_w [3];
    int          mbad_w [3];
    logic [31:0] fcmd_w [3];

    int vectors     = 0;
    int miscompares = 0;

    function automatic int abits_of(input int g);
        return (g == 1) ? 4 : 13;
    endfunction

    function automatic int clkdiv_of(input int g);
        return (g == 2) ? 3 : 1;
    endfunction

    function automatic int eff_len(input int g);
        int l;
        l = int'(img[g][0]);
        if (l == 65535) return 0;
        if (l > (1 << abits_of(g))) return 1 << abits_of(g);
        return l;
    endfunction

    function automatic logic flash_bit(input int g, input int b);
        logic [15:0] w;
        w = img[g][(b / 16) % 128];
        return w[15 - (b % 16)];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int AB = (g == 1) ? 4 : 13;
        localparam int CD = (g == 2) ? 3 : 1;

        code_loader #(.ABITS(AB), .CLKDIV(CD), .BASE(24'h000000)) u_dut (
            .clk        (clk),
            .resetq     (rstq[g]),
            .cpu_resetq (cpu_rq[g]),
            .boot_done  (bdone[g]),
            .boot_err   (berr[g]),
            .code_addr  (caddr[g]),
            .insn       (insn[g]),
            .spi_cs_n   (cs_n[g]),
            .spi_sck    (sck[g]),
            .spi_mosi   (mosi[g]),
            .spi_miso   (miso[g])
        );

        // Flash: counts SCK rising edges in a session, captures the command,
        // then presents image bits (header first) MSB-first.
        int          fcnt   = 0;
        int          sbits  = 0;
        logic [31:0] fcmd   = '0;
        logic        f_miso = 1'b0;

        always @(posedge sck[g] or posedge cs_n[g]) begin
            if (cs_n[g]) begin
                if (fcnt != 0) sbits <= fcnt;
                fcnt   <= 0;
                f_miso <= 1'b0;
            end else begin
                if (fcnt < 32) fcmd <= {fcmd[30:0], mosi[g]};
                fcnt <= fcnt + 1;
                if (fcnt + 1 >= 32) f_miso <= flash_bit(g, fcnt + 1 - 32);
                else                f_miso <= 1'b0;
            end
        end

        // Phase-length and MOSI-stability monitor.
        int   run    = 0;
        int   pmin   = 1000;
        int   pmax   = 0;
        int   mbad   = 0;
        logic sck_p  = 1'b0;
        logic mosi_p = 1'b0;

        always @(negedge clk) begin
            if (cs_n[g] !== 1'b0) begin
                run <= 0;
            end else if (sck[g] !== sck_p) begin
                if (run < pmin) pmin <= run;
                if (run > pmax) pmax <= run;
                run <= 1;
            end else begin
                run <= run + 1;
            end
            if (sck[g] === 1'b1 && mosi[g] !== mosi_p) mbad <= mbad + 1;
            sck_p  <= sck[g];
            mosi_p <= mosi[g];
        end

        assign miso[g]    = f_miso;
        assign fcnt_w[g]  = fcnt;
        assign sbits_w[g] = sbits;
        assign fcmd_w[g]  = fcmd;
        assign pmin_w[g]  = pmin;
        assign pmax_w[g]  = pmax;
        assign mbad_w[g]  = mbad;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_check(input int g, input string tag);
        check({tag, "_cpu_resetq"}, 32'(cpu_rq[g]), 32'd0);
        check({tag, "_boot_done"},  32'(bdone[g]),  32'd0);
        check({tag, "_boot_err"},   32'(berr[g]),   32'd0);
        check({tag, "_cs_n"},       32'(cs_n[g]),   32'd1);
        check({tag, "_sck"},        32'(sck[g]),    32'd0);
        check({tag, "_mosi"},       32'(mosi[g]),   32'd0);
        check({tag, "_insn"},       32'(insn[g]),   32'd0);
    endtask

    task automatic hold_reset(input int g);
        @(negedge clk);
        rstq[g] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic fetch(input int g, input int a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        caddr[g] = 15'(a);
        @(posedge clk);
        #1;
        check(tag, 32'(insn[g]), 32'(exp));
    endtask

    task automatic load_and_check(input int g, input string tag);
        int cyc;
        int n;
        int expc;
        n    = eff_len(g);
        expc = 1 + (48 + 16 * n) * 2 * clkdiv_of(g) + 2;
        @(negedge clk);
        rstq[g] = 1'b1;
        cyc = 0;
        while (cpu_rq[g] !== 1'b1 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        vectors++;
        assert (cyc >= expc - 1 && cyc <= expc + 1) else begin
            miscompares++;
            $error("FAIL %s_cycles observed=%0d expected=%0d", tag, cyc, expc);
        end
        @(negedge clk);
        check({tag, "_boot_done"}, 32'(bdone[g]), 32'd1);
        check({tag, "_boot_err"},  32'(berr[g]),  (img[g][0] == 16'hFFFF) ? 32'd1 : 32'd0);
        check({tag, "_cs_n"},      32'(cs_n[g]),  32'd1);
        check({tag, "_sck"},       32'(sck[g]),   32'd0);
        check({tag, "_cmd"},       fcmd_w[g],     32'h03000000);
        check({tag, "_bits"},      32'(sbits_w[g]), 32'(48 + 16 * n));
        for (int i = 0; i < n; i++)
            fetch(g, i, img[g][i + 1], $sformatf("%s_w%0d", tag, i));
    endtask

    initial begin
        int waited;
        for (int g = 0; g < 3; g++) begin
            caddr[g] = '0;
            for (int i = 0; i < 128; i++) img[g][i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) reset_check(g, $sformatf("rst%0d", g));

        // Directed image.
        img[0][0] = 16'd3;
        img[0][1] = 16'h8001;
        img[0][2] = 16'hF123;
        img[0][3] = 16'h0ABC;
        load_and_check(0, "len3");
        fetch(0, 1, 16'hF123, "fetch_addr1");

        // Blank flash: RAM must keep the previous image.
        hold_reset(0);
        img[0][0] = 16'hFFFF;
        load_and_check(0, "blank");
        check("blank_cpu_resetq", 32'(cpu_rq[0]), 32'd1);
        fetch(0, 0, 16'h8001, "blank_keep0");
        fetch(0, 2, 16'h0ABC, "blank_keep2");

        // Zero-length image.
        hold_reset(0);
        img[0][0] = 16'd0;
        load_and_check(0, "len0");
        fetch(0, 1, 16'hF123, "len0_keep1");

        // Random image.
        hold_reset(0);
        img[0][0] = 16'($urandom_range(1, 40));
        for (int i = 1; i <= 40; i++) img[0][i] = 16'($urandom);
        load_and_check(0, "rand");

        // Reset in the middle of the sixth data word, then reload a new image.
        hold_reset(0);
        img[0][0] = 16'd20;
        for (int i = 1; i <= 20; i++) img[0][i] = 16'($urandom);
        @(negedge clk);
        rstq[0] = 1'b1;
        waited = 0;
        while (fcnt_w[0] < 48 + 16 * 5 + 5 && waited < 5000) begin
            @(posedge clk);
            waited++;
            #1;
        end
        check("midrst_reached", (waited < 5000) ? 32'd1 : 32'd0, 32'd1);
        #2;
        rstq[0] = 1'b0;
        #1;
        reset_check(0, "midrst");
        for (int i = 1; i <= 20; i++) img[0][i] = ~img[0][i];
        repeat (2) @(negedge clk);
        load_and_check(0, "reload");

        // Oversized header against a 16-word RAM.
        img[1][0] = 16'd100;
        for (int i = 1; i <= 100; i++) img[1][i] = 16'($urandom);
        load_and_check(1, "clamp");

        // Slow SCK: every phase exactly three clocks, MOSI steady while high.
        img[2][0] = 16'd4;
        for (int i = 1; i <= 4; i++) img[2][i] = 16'($urandom);
        load_and_check(2, "div3");
        check("div3_phase_min", 32'(pmin_w[2]), 32'd3);
        check("div3_phase_max", 32'(pmax_w[2]), 32'd3);
        check("div3_mosi_stable", 32'(mbad_w[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
